// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package mem_arb_pkg;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;

  localparam logic PORT_LS  = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = mem_arb_pkg::DEF_AW,
  parameter int DW = mem_arb_pkg::DEF_DW
);
  logic          p0_req_valid;
  logic          p0_req_we;
  logic [AW-1:0] p0_req_addr;
  logic [DW-1:0] p0_req_wdata;
  logic          p0_req_ready;
  logic          p1_req_valid;
  logic          p1_req_we;
  logic [AW-1:0] p1_req_addr;
  logic [DW-1:0] p1_req_wdata;
  logic          p1_req_ready;
  logic          rsp_valid;
  logic          rsp_id;
  logic [DW-1:0] rsp_rdata;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic          busy;

  modport slave (
    input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
    output p0_req_ready,
    input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
    output p1_req_ready,
    output rsp_valid, rsp_id, rsp_rdata,
    output mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
    input  mem_rd_data,
    output busy
  );

  modport master (
    output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
    input  p0_req_ready,
    output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
    input  p1_req_ready,
    input  rsp_valid, rsp_id, rsp_rdata,
    input  mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_en, mem_rd_addr,
    output mem_rd_data,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       en,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       winner
);
  always_comb begin
    gnt    = 2'b00;
    winner = 1'b0;
    if (en && (req != 2'b00)) begin
      winner      = (req == 2'b11) ? ptr : req[1];
      gnt[winner] = 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data memory between the load/store port and the loader/debug port.
//   state   | meaning
//   IDLE    | arbitrate; write grants stay here, a read grant moves to RD_WAIT
//   RD_WAIT | memory returning read data; no grants, response registered
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  arb_state_t    state_q, state_d;
  logic          rr_ptr_q;
  logic          rd_owner_q;
  logic          rsp_valid_q;
  logic          rsp_id_q;
  logic [DW-1:0] rsp_rdata_q;
  logic [1:0]    gnt;
  logic          winner;
  logic          grant;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Reset gates the arbiter so no handshake completes during a reset cycle.
  rr_arb2 u_rr_arb2 (
    .req    ({bus.p1_req_valid, bus.p0_req_valid}),
    .en     ((state_q == IDLE) && !rst),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .winner (winner)
  );

  assign grant     = |gnt;
  assign win_we    = (winner == PORT_DBG) ? bus.p1_req_we    : bus.p0_req_we;
  assign win_addr  = (winner == PORT_DBG) ? bus.p1_req_addr  : bus.p0_req_addr;
  assign win_wdata = (winner == PORT_DBG) ? bus.p1_req_wdata : bus.p0_req_wdata;

  assign bus.p0_req_ready = gnt[PORT_LS];
  assign bus.p1_req_ready = gnt[PORT_DBG];
  assign bus.busy         = (state_q == RD_WAIT);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_rdata    = rsp_rdata_q;

  always_comb begin
    state_d         = state_q;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = '0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          if (win_we) begin
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_addr = win_addr;
            bus.mem_wr_data = win_wdata;
          end else begin
            bus.mem_rd_en   = 1'b1;
            bus.mem_rd_addr = win_addr;
            state_d         = RD_WAIT;
          end
        end
      end
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PORT_LS;
      rd_owner_q  <= PORT_LS;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= (state_q == RD_WAIT);
      if (grant) rr_ptr_q <= ~winner;
      if (bus.mem_rd_en) rd_owner_q <= winner;
      if (state_q == RD_WAIT) begin
        rsp_rdata_q <= bus.mem_rd_data;
        rsp_id_q    <= rd_owner_q;
      end
    end
  end
endmodule
